// File: rtl/run_ctrl.sv
// run_ctrl: host-driven run / single-step / halt sequencer that freezes the fetch stage.
// Define RUN_CTRL_BREAKPOINT_EN to build the PC breakpoint register and comparator.
module run_ctrl #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_cmd_valid,
  input  logic [1:0]       i_cmd,
  output logic             o_cmd_ready,
  input  logic [PC_W-1:0]  i_pc,
  input  logic             i_stall,
  input  logic             i_halt_instr,
  input  logic             i_bp_we,
  input  logic [PC_W-1:0]  i_bp_addr,
  input  logic             i_bp_arm,
  output logic             o_halt,
  output logic [1:0]       o_state,
  output logic             o_step_done,
  output logic             o_bp_hit,
  output logic [CNT_W-1:0] o_cycle_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_STEP = 2'b10,
    S_DONE = 2'b11
  } state_t;

  localparam logic [1:0] CMD_RUN  = 2'b01;
  localparam logic [1:0] CMD_STEP = 2'b10;
  localparam logic [1:0] CMD_HALT = 2'b11;

  state_t           r_state;
  state_t           w_next_state;
  logic             r_step_done;
  logic             r_bp_hit;
  logic             w_step_done;
  logic             w_bp_hit;
  logic             w_bp_match;
  logic             w_cmd_acc;
  logic [CNT_W-1:0] r_cycle_count;

  assign o_cmd_ready = (r_state == S_IDLE) || (r_state == S_RUN);
  assign w_cmd_acc   = i_cmd_valid & o_cmd_ready;

`ifdef RUN_CTRL_BREAKPOINT_EN
  logic [PC_W-1:0] r_bp_addr;
  logic            r_bp_armed;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_bp_addr  <= '0;
      r_bp_armed <= 1'b0;
    end else if (i_bp_we) begin
      r_bp_addr  <= i_bp_addr;
      r_bp_armed <= i_bp_arm;
    end
  end

  // A stalled match is not a hit: the instruction at the address has not been fetched yet.
  assign w_bp_match = r_bp_armed && (i_pc == r_bp_addr) && !i_stall;
`else
  logic w_unused_bp;
  assign w_unused_bp = ^{i_bp_we, i_bp_addr, i_bp_arm, i_pc};
  assign w_bp_match  = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state     <= S_IDLE;
      r_step_done <= 1'b0;
      r_bp_hit    <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_step_done <= w_step_done;
      r_bp_hit    <= w_bp_hit;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_step_done  = 1'b0;
    w_bp_hit     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_cmd_acc && (i_cmd == CMD_RUN))
          w_next_state = S_RUN;
        else if (w_cmd_acc && (i_cmd == CMD_STEP))
          w_next_state = S_STEP;
      end
      // Retired HALT outranks the breakpoint, which outranks a host HALT.
      S_RUN: begin
        if (i_halt_instr) begin
          w_next_state = S_DONE;
        end else if (w_bp_match) begin
          w_next_state = S_IDLE;
          w_bp_hit     = 1'b1;
        end else if (w_cmd_acc && (i_cmd == CMD_HALT)) begin
          w_next_state = S_IDLE;
        end
      end
      S_STEP: begin
        if (!i_stall) begin
          w_next_state = i_halt_instr ? S_DONE : S_IDLE;
          w_step_done  = 1'b1;
        end
      end
      S_DONE: w_next_state = S_DONE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n)
      r_cycle_count <= '0;
    else if ((r_state == S_RUN) || (r_state == S_STEP))
      r_cycle_count <= r_cycle_count + 1'b1;
  end

  assign o_halt        = (r_state == S_IDLE) || (r_state == S_DONE);
  assign o_state       = r_state;
  assign o_step_done   = r_step_done;
  assign o_bp_hit      = r_bp_hit;
  assign o_cycle_count = r_cycle_count;

endmodule
